biphase_link_ctrl: RTL and testbench
====================================

# biphase_link_ctrl

Link-level controller that sits directly behind the biphase-to-NRZ decoder on the Symbolics console keyboard/mouse path. It consumes the decoder's per-bit strobes and error pulses and frames the NRZ bit stream into start/data/stop words. It tracks link health, decides when the link is up, and on repeated framing errors sequences a resynchronisation by resetting the decoder. Completed words go to the host side through a one-entry valid/ready holding register.

## Interface
Parameters:
- WORD_BITS, 8, data bits per word, LSB first, range 5..9
- IDLE_BITS, 4, consecutive marking (1) bits required to declare link up
- MAX_ERRORS, 3, consecutive framing errors that trigger a resync, ≥1
- RESYNC_CYCLES, 16, clocks `dec_rst` is held high during a resync, ≥2
- STAT_WIDTH, 16, width of the statistics counters

Ports:
- clk  in  1  system clock; one clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- bit_valid  in  1  decoder data-received strobe, one clock wide
- bit_data  in  1  decoder NRZ value, sampled when `bit_valid` is high
- framing_error  in  1  decoder framing-error strobe
- glitch_ignored  in  1  decoder glitch strobe
- dec_rst  out  1  synchronous reset request to the decoder
- link_up  out  1  high in the IDLE, START_WAIT, DATA and STOP states
- word_data  out  WORD_BITS  held word
- word_valid  out  1  the held word is valid
- word_ready  in  1  the consumer accepts the word
- overrun  out  1  sticky flag; cleared only by reset
- cnt_words, cnt_ferr, cnt_glitch, cnt_overrun  out  STAT_WIDTH each  statistics

## Operation
The state machine has these states: HUNT, IDLE, DATA, STOP, RESYNC. (`link_up` also names START_WAIT, but the transitions below never enter it; the interface line is kept as written.)

- **Reset**: state = HUNT. All outputs are 0, including `dec_rst`.
- **Internal counters**: `idle_cnt`, `bit_idx`, `err_consec`, `rs_cnt`.
- **HUNT**
  - Each `bit_valid` with `bit_data`=1 increments `idle_cnt`. A 0 clears it.
  - When `idle_cnt` reaches IDLE_BITS, go to IDLE.
- **IDLE**
  - `bit_valid` with 1: stay.
  - `bit_valid` with 0 (start bit): go to DATA with `bit_idx` = 0.
- **DATA**
  - Each `bit_valid` shifts `bit_data` into the shift register at position `bit_idx`.
  - After bit WORD_BITS-1, go to STOP.
- **STOP**
  - `bit_valid` with 1: the word is good.
    - Clear `err_consec`.
    - Present the word and go to IDLE.
  - `bit_valid` with 0: stop-bit error. Treat it exactly as a framing error.
- **Framing error** (`framing_error` in HUNT, IDLE, DATA or STOP, or a bad stop bit)
  - Discard any partial word.
  - Clear `idle_cnt`.
  - Increment `err_consec`, saturating.
  - If the new value equals MAX_ERRORS, go to RESYNC. Otherwise go to HUNT.
- **RESYNC**
  - `dec_rst` is high for exactly RESYNC_CYCLES clocks.
  - Then go to HUNT with `err_consec` = 0.
  - All decoder inputs are ignored, and not counted, during RESYNC.
- **Simultaneous `framing_error` and `bit_valid`**: the error wins and the bit is discarded.
- **`glitch_ignored`**: affects statistics only, never the state.
- **Holding register**
  - On a good word with `word_valid`=0, or with `word_valid`=1 and `word_ready`=1 in the same cycle: load `word_data` and set `word_valid`.
  - On a good word with `word_valid`=1 and `word_ready`=0:
    - Keep the old word.
    - Drop the new word.
    - Set `overrun`.
    - Increment `cnt_overrun`.
  - `word_valid` clears on `word_ready` when no new word loads.
  - The register is not flushed by a resync or by HUNT.

## Timing
- `word_valid` rises on the clock after the stop bit's `bit_valid`.
- `word_data` is stable while `word_valid`=1 and `word_ready`=0.
- `dec_rst` rises on the clock after the error that triggers the resync, and stays high for RESYNC_CYCLES clocks.
- `link_up` is registered. It falls on the clock after any framing error and rises on the clock after the IDLE_BITS-th marking bit.
- All status outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: `BIPHASE_LINK_STATS_EN`.
- **Defined**:
  - `cnt_words` counts good words, including dropped ones.
  - `cnt_ferr` counts framing errors, including stop-bit errors.
  - `cnt_glitch` counts glitch strobes.
  - `cnt_overrun` counts dropped words.
  - Every counter saturates at all-ones and resets to 0.
- **Undefined**:
  - All four counter outputs are tied to 0 and no counter flops exist.
  - `overrun` still operates.

## Structure
- **Shared package `biphase_pkg`**:
  - state enum `link_state_t`
  - a saturating-increment function
  - default parameter constants
- **Sub-module `biphase_word_hold`**: the one-entry valid/ready holding register with overrun detection.
- The block is intended to be instantiated alongside the decoder, with `dec_rst` ORed into the decoder's reset.

## Test plan
The following scenarios use the defaults: WORD_BITS=8, IDLE_BITS=4, MAX_ERRORS=3.

1. Reset followed by four 1 bits → `link_up`=1 one clock after the 4th bit. Three 1 bits followed by a 0 → `link_up` stays 0.
2. Link up, then start 0, data 0xA5 LSB first, stop 1, with `word_ready`=1 → `word_data`=0xA5 and `word_valid` high for one clock, on the clock after the stop bit. `cnt_words`=1.
3. Link up, `word_ready`=0, two frames 0x12 then 0x34 → `word_data` holds 0x12, `overrun`=1, `cnt_overrun`=1.
4. Frame with stop bit 0 → `link_up` drops, no word is presented, `cnt_ferr`=1, state HUNT.
5. Three framing errors with no good word between them → `dec_rst` high for exactly 16 clocks. Bits injected during those clocks are not counted. Four 1 bits afterwards → `link_up`=1.
6. `framing_error` and `bit_valid` asserted together mid-DATA → partial word discarded, `cnt_ferr`+1. A `glitch_ignored` pulse in IDLE → `cnt_glitch`+1, state unchanged.

Source files
------------

// File: rtl/biphase_pkg.sv
// biphase_pkg: shared state type, default parameters and saturating increment for the biphase link controller
package biphase_pkg;

    localparam int DEF_WORD_BITS     = 8;
    localparam int DEF_IDLE_BITS     = 4;
    localparam int DEF_MAX_ERRORS    = 3;
    localparam int DEF_RESYNC_CYCLES = 16;
    localparam int DEF_STAT_WIDTH    = 16;

    // START_WAIT is part of the link_up set but no transition enters it
    typedef enum logic [2:0] {
        ST_HUNT,
        ST_IDLE,
        ST_START_WAIT,
        ST_DATA,
        ST_STOP,
        ST_RESYNC
    } link_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/biphase_word_hold.sv
// biphase_word_hold: one-entry valid/ready holding register with overrun detection
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   good_i, data_i      a completed word is offered this cycle
//   ready_i             consumer accepts the held word
//   data_o, valid_o     held word and its valid flag (registered)
//   overrun_o           sticky: a word was dropped because the register was full
//   drop_o              one-cycle pulse when a word is dropped
module biphase_word_hold #(
    parameter int WORD_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 good_i,
    input  logic [WORD_BITS-1:0] data_i,
    input  logic                 ready_i,
    output logic [WORD_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 overrun_o,
    output logic                 drop_o
);

    logic                 load;
    logic                 valid_q, valid_d;
    logic                 ovr_q;
    logic [WORD_BITS-1:0] data_q;

    assign load    = good_i && (!valid_q || ready_i);
    assign drop_o  = good_i && valid_q && !ready_i;
    assign valid_d = load || (valid_q && !ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (load) data_q <= data_i;
            valid_q <= valid_d;
            ovr_q   <= ovr_q || drop_o;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/biphase_link_ctrl.sv
// biphase_link_ctrl: frames decoder NRZ bits into start/data/stop words, tracks link health, sequences resync
// Build option: define BIPHASE_LINK_STATS_EN to include the saturating statistics counters.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   bit_valid, bit_data              decoder bit strobe and NRZ value
//   framing_error, glitch_ignored    decoder error / glitch strobes
//   dec_rst                          decoder reset request during resync
//   link_up                          link is framed (IDLE/START_WAIT/DATA/STOP)
//   word_data, word_valid, word_ready  holding-register handshake
//   overrun                          sticky dropped-word flag
//   cnt_words, cnt_ferr, cnt_glitch, cnt_overrun  statistics (0 when stats are compiled out)
module biphase_link_ctrl
    import biphase_pkg::*;
#(
    parameter int WORD_BITS     = DEF_WORD_BITS,
    parameter int IDLE_BITS     = DEF_IDLE_BITS,
    parameter int MAX_ERRORS    = DEF_MAX_ERRORS,
    parameter int RESYNC_CYCLES = DEF_RESYNC_CYCLES,
    parameter int STAT_WIDTH    = DEF_STAT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    input  logic                  framing_error,
    input  logic                  glitch_ignored,
    output logic                  dec_rst,
    output logic                  link_up,
    output logic [WORD_BITS-1:0]  word_data,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  overrun,
    output logic [STAT_WIDTH-1:0] cnt_words,
    output logic [STAT_WIDTH-1:0] cnt_ferr,
    output logic [STAT_WIDTH-1:0] cnt_glitch,
    output logic [STAT_WIDTH-1:0] cnt_overrun
);

    localparam int BW = $clog2(WORD_BITS);
    localparam int IW = $clog2(IDLE_BITS + 1);
    localparam int EW = $clog2(MAX_ERRORS + 1);
    localparam int RW = $clog2(RESYNC_CYCLES);

    link_state_t          state_q, state_d;
    logic [IW-1:0]        idle_q, idle_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [EW-1:0]        err_q, err_d, err_inc;
    logic [RW-1:0]        rs_q, rs_d;
    logic [WORD_BITS-1:0] sh_q, sh_d;
    logic                 link_q, dec_rst_q;
    logic                 good, ferr, drop;

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        idx_d   = idx_q;
        err_d   = err_q;
        rs_d    = rs_q;
        sh_d    = sh_q;
        good    = 1'b0;
        ferr    = 1'b0;
        err_inc = EW'(sat_inc(32'(err_q), MAX_ERRORS));
        if (state_q == ST_RESYNC) begin
            rs_d = rs_q + 1'b1;
            if (rs_q == RW'(RESYNC_CYCLES - 1)) begin
                state_d = ST_HUNT;
                rs_d    = '0;
                err_d   = '0;
            end
        // An explicit error or a bad stop bit; an error beats a coincident bit
        end else if (framing_error || (state_q == ST_STOP && bit_valid && !bit_data)) begin
            ferr    = 1'b1;
            idle_d  = '0;
            rs_d    = '0;
            err_d   = err_inc;
            state_d = (err_inc == EW'(MAX_ERRORS)) ? ST_RESYNC : ST_HUNT;
        end else if (bit_valid) begin
            case (state_q)
                ST_HUNT: begin
                    idle_d = bit_data ? idle_q + 1'b1 : '0;
                    if (bit_data && idle_q == IW'(IDLE_BITS - 1)) state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (!bit_data) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end
                end
                ST_DATA: begin
                    sh_d[idx_q] = bit_data;
                    idx_d       = idx_q + 1'b1;
                    if (idx_q == BW'(WORD_BITS - 1)) state_d = ST_STOP;
                end
                ST_STOP: begin
                    good    = 1'b1;
                    err_d   = '0;
                    state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            idle_q    <= '0;
            idx_q     <= '0;
            err_q     <= '0;
            rs_q      <= '0;
            sh_q      <= '0;
            link_q    <= 1'b0;
            dec_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            rs_q      <= rs_d;
            sh_q      <= sh_d;
            link_q    <= state_d inside {ST_IDLE, ST_START_WAIT, ST_DATA, ST_STOP};
            dec_rst_q <= state_d == ST_RESYNC;
        end
    end

    assign link_up = link_q;
    assign dec_rst = dec_rst_q;

    biphase_word_hold #(.WORD_BITS(WORD_BITS)) u_hold (
        .clk      (clk),
        .rst_n    (rst_n),
        .good_i   (good),
        .data_i   (sh_q),
        .ready_i  (word_ready),
        .data_o   (word_data),
        .valid_o  (word_valid),
        .overrun_o(overrun),
        .drop_o   (drop)
    );

`ifdef BIPHASE_LINK_STATS_EN
    localparam logic [31:0] SMAX = 32'({STAT_WIDTH{1'b1}});

    logic [STAT_WIDTH-1:0] words_q, ferr_q, glitch_q, ovr_q;

    function automatic logic [STAT_WIDTH-1:0] bump(input logic [STAT_WIDTH-1:0] v);
        return STAT_WIDTH'(sat_inc(32'(v), SMAX));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q  <= '0;
            ferr_q   <= '0;
            glitch_q <= '0;
            ovr_q    <= '0;
        end else begin
            if (good) words_q <= bump(words_q);
            if (ferr) ferr_q <= bump(ferr_q);
            if (glitch_ignored && state_q != ST_RESYNC) glitch_q <= bump(glitch_q);
            if (drop) ovr_q <= bump(ovr_q);
        end
    end

    assign cnt_words   = words_q;
    assign cnt_ferr    = ferr_q;
    assign cnt_glitch  = glitch_q;
    assign cnt_overrun = ovr_q;
`else
    logic unused_stats;
    assign unused_stats = ^{glitch_ignored, ferr, drop};
    assign cnt_words    = '0;
    assign cnt_ferr     = '0;
    assign cnt_glitch   = '0;
    assign cnt_overrun  = '0;
`endif

endmodule

// File: tb/tb_biphase_link_ctrl.sv
// tb_biphase_link_ctrl: directed test-plan scenarios plus randomized traffic checked against a behavioural link model
module tb_biphase_link_ctrl;

    localparam int WB = 8;
    localparam int IB = 4;
    localparam int ME = 3;
    localparam int RC = 16;
    localparam int SW = 16;
`ifdef BIPHASE_LINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bit_valid, bit_data, framing_error, glitch_ignored, word_ready;
    logic          dec_rst, link_up, word_valid, overrun;
    logic [WB-1:0] word_data;
    logic [SW-1:0] cnt_words, cnt_ferr, cnt_glitch, cnt_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the link: hunting for marking bits, then framing words
    int       m_ones, m_errs, m_rs;
    int       m_words, m_ferr, m_glitch, m_novr;
    bit       m_up, m_frame, m_valid, m_ovr;
    logic [7:0] m_data;
    logic     m_bits[$];

    always #5 clk = ~clk;

    biphase_link_ctrl #(
        .WORD_BITS(WB), .IDLE_BITS(IB), .MAX_ERRORS(ME), .RESYNC_CYCLES(RC), .STAT_WIDTH(SW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bit_valid     (bit_valid),
        .bit_data      (bit_data),
        .framing_error (framing_error),
        .glitch_ignored(glitch_ignored),
        .dec_rst       (dec_rst),
        .link_up       (link_up),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .overrun       (overrun),
        .cnt_words     (cnt_words),
        .cnt_ferr      (cnt_ferr),
        .cnt_glitch    (cnt_glitch),
        .cnt_overrun   (cnt_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] st(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic model(input logic bv, input logic bd, input logic fe, input logic gl, input logic rdy);
        bit         good = 1'b0;
        logic [7:0] w = '0;
        if (m_rs > 0) begin
            m_rs--;
            if (m_rs == 0) m_errs = 0;
        end else begin
            if (gl) m_glitch++;
            if (fe || (m_frame && m_bits.size() == WB && bv && !bd)) begin
                m_up = 0;
                m_frame = 0;
                m_bits.delete();
                m_ones = 0;
                m_ferr++;
                if (m_errs < ME) m_errs++;
                if (m_errs == ME) m_rs = RC;
            end else if (bv) begin
                if (!m_up) begin
                    m_ones = bd ? m_ones + 1 : 0;
                    if (m_ones == IB) m_up = 1;
                end else if (!m_frame) begin
                    if (!bd) begin
                        m_frame = 1;
                        m_bits.delete();
                    end
                end else if (m_bits.size() < WB) begin
                    m_bits.push_back(bd);
                end else begin
                    good = 1'b1;
                    m_frame = 0;
                    m_errs = 0;
                    foreach (m_bits[i]) w[i] = m_bits[i];
                end
            end
        end
        if (good) begin
            m_words++;
            if (!m_valid || rdy) begin
                m_data  = w;
                m_valid = 1;
            end else begin
                m_ovr = 1;
                m_novr++;
            end
        end else if (rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("link_up", link_up, m_up);
        check("dec_rst", dec_rst, m_rs > 0);
        check("word_valid", word_valid, m_valid);
        check("word_data", word_data, m_data);
        check("overrun", overrun, m_ovr);
        check("cnt_words", cnt_words, st(m_words));
        check("cnt_ferr", cnt_ferr, st(m_ferr));
        check("cnt_glitch", cnt_glitch, st(m_glitch));
        check("cnt_overrun", cnt_overrun, st(m_novr));
    endtask

    // Called at a negedge: drive, let one active edge pass, then compare
    task automatic tick(input logic bv, input logic bd, input logic fe, input logic gl, input logic rdy);
        bit_valid      = bv;
        bit_data       = bd;
        framing_error  = fe;
        glitch_ignored = gl;
        word_ready     = rdy;
        @(posedge clk);
        model(bv, bd, fe, gl, rdy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic send(input logic bd, input logic rdy);
        tick(1'b1, bd, 1'b0, 1'b0, rdy);
        tick(1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic frame_body(input logic [7:0] d, input logic rdy);
        send(1'b0, rdy);
        for (int i = 0; i < WB; i++) send(d[i], rdy);
    endtask

    task automatic link_ones(input logic rdy);
        for (int i = 0; i < IB; i++) send(1'b1, rdy);
    endtask

    initial begin
        int rs_seen;
        rst_n = 1'b0;
        bit_valid = 0; bit_data = 0; framing_error = 0; glitch_ignored = 0; word_ready = 0;
        m_ones = 0; m_errs = 0; m_rs = 0; m_words = 0; m_ferr = 0; m_glitch = 0; m_novr = 0;
        m_up = 0; m_frame = 0; m_valid = 0; m_ovr = 0; m_data = '0;
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // 1: three marks then a space keeps the link down; four marks bring it up
        send(1, 1); send(1, 1); send(1, 1); send(0, 1);
        check("s1_down", link_up, 1'b0);
        send(1, 1); send(1, 1); send(1, 1);
        tick(1, 1, 0, 0, 1);
        check("s1_up", link_up, 1'b1);
        tick(0, 0, 0, 0, 1);

        // 2: one good word with the consumer ready
        frame_body(8'hA5, 1);
        tick(1, 1, 0, 0, 1);
        check("s2_valid", word_valid, 1'b1);
        check("s2_data", word_data, 8'hA5);
        tick(0, 0, 0, 0, 1);
        check("s2_valid_drop", word_valid, 1'b0);

        // 3: consumer stalled, second word is dropped
        frame_body(8'h12, 0); send(1, 0);
        frame_body(8'h34, 0); send(1, 0);
        check("s3_data", word_data, 8'h12);
        check("s3_overrun", overrun, 1'b1);
        tick(0, 0, 0, 0, 1);

        // 4: bad stop bit
        frame_body(8'h5A, 1);
        tick(1, 0, 0, 0, 1);
        check("s4_down", link_up, 1'b0);
        check("s4_novalid", word_valid, 1'b0);

        // 5: two more errors reach the limit and start a resync
        tick(0, 0, 1, 0, 1);
        tick(0, 0, 1, 0, 1);
        rs_seen = dec_rst ? 1 : 0;
        for (int i = 0; i < RC + 8; i++) begin
            if (i < RC - 1) tick($urandom_range(1), $urandom_range(1), $urandom_range(1), $urandom_range(1), 1);
            else tick(0, 0, 0, 0, 1);
            if (dec_rst) rs_seen++;
        end
        check("s5_rs_len", rs_seen, RC);
        link_ones(1);
        check("s5_up", link_up, 1'b1);

        // 6: error coincident with a data bit, then a glitch while idle
        send(0, 1); send(1, 1); send(0, 1);
        tick(1, 1, 1, 0, 1);
        check("s6_down", link_up, 1'b0);
        link_ones(1);
        tick(0, 0, 0, 1, 1);
        check("s6_glitch_up", link_up, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom % 3) == 0, ($urandom % 8) != 0, ($urandom % 150) == 0,
                 ($urandom % 30) == 0, $urandom_range(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
